// File: rtl/char_motion_ctl.sv
// char_motion_ctl
// Character motion controller for a Jump King style platformer. It owns the
// sprite's position, pose, facing and level. Keys and the platform surface
// are sampled only on frame_tick, and every output comes straight from a
// register or from register state.
//
// Ports
//   clk             system clock
//   rst             synchronous active-high reset
//   frame_tick      one-cycle pulse per frame, gates every motion update
//   key_space       jump key, held = charging
//   key_left        walk / steer left
//   key_right       walk / steer right
//   plat_valid      a platform exists under the sprite's current x-span
//   plat_top        y of that platform's top surface
//   value_x         sprite left x
//   value_y         sprite top y
//   character_state 00 ground, 01 charging, 10 rising, 11 falling
//   facing          1 = right, 0 = left
//   level           current screen index, 0 = bottom
//   jump_vel        current charge velocity
//   landed          one-clock pulse on the tick that ends an airborne phase
module char_motion_ctl #(
  parameter int CW         = 12,
  parameter int SCREEN_W   = 1024,
  parameter int SCREEN_H   = 768,
  parameter int CHAR_W     = 47,
  parameter int CHAR_H     = 63,
  parameter int X_INIT     = 488,
  parameter int WALK_STEP  = 2,
  parameter int VX_JUMP    = 4,
  parameter int JUMP_VMAX  = 24,
  parameter int CHARGE_DIV = 4,
  parameter int VFALL_MAX  = 16,
  parameter int LEVELS     = 4,
  localparam int LW        = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_tick,
  input  logic          key_space,
  input  logic          key_left,
  input  logic          key_right,
  input  logic          plat_valid,
  input  logic [CW-1:0] plat_top,
  output logic [CW-1:0] value_x,
  output logic [CW-1:0] value_y,
  output logic [1:0]    character_state,
  output logic          facing,
  output logic [LW-1:0] level,
  output logic [4:0]    jump_vel,
  output logic          landed
);

  // Two guard bits let x+vx and y-vy go negative or past the screen edge
  // without wrapping, so the edge tests below are plain signed compares.
  localparam int IW    = CW + 2;
  localparam int FLOOR = SCREEN_H - CHAR_H;
  localparam int XMAX  = SCREEN_W - CHAR_W - 1;

  typedef logic signed [IW-1:0] sword_t;

  localparam sword_t ZERO_S      = sword_t'(0);
  localparam sword_t ONE_S       = sword_t'(1);
  localparam sword_t FLOOR_S     = sword_t'(FLOOR);
  localparam sword_t XMAX_S      = sword_t'(XMAX);
  localparam sword_t CHARH_S     = sword_t'(CHAR_H);
  localparam sword_t WALK_S      = sword_t'(WALK_STEP);
  localparam sword_t VXJ_S       = sword_t'(VX_JUMP);
  localparam sword_t NEG_VFALL_S = sword_t'(-VFALL_MAX);

  localparam logic [CW-1:0] X_INIT_C  = CW'(X_INIT);
  localparam logic [CW-1:0] FLOOR_C   = CW'(FLOOR);
  localparam logic [4:0]    VMAX_C    = 5'(JUMP_VMAX);
  localparam logic [15:0]   VMAX16_C  = 16'(JUMP_VMAX);
  localparam logic [15:0]   DIV_C     = 16'(CHARGE_DIV);
  localparam logic [LW-1:0] LEVEL_TOP = LW'(LEVELS - 1);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    CHARGE = 2'd1,
    AIR    = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic [LW-1:0] level_q, level_d;
  logic          facing_q, facing_d;
  logic [4:0]    jumpVel_q, jumpVel_d;
  logic          landed_q, landed_d;
  sword_t        vx_q, vx_d;
  sword_t        vy_q, vy_d;
  logic [15:0]   chargeCnt_q, chargeCnt_d;

  sword_t      xNext, yNext, vyNext;
  sword_t      xS, yS, platS;
  logic        supported, landNow, launch;
  logic [15:0] cntInc, velCalc;

  function automatic sword_t toS(input logic [CW-1:0] v);
    return sword_t'({2'b00, v});
  endfunction

  assign xS    = toS(x_q);
  assign yS    = toS(y_q);
  assign platS = toS(plat_top);

  // Standing is legal on the bottom screen's floor or flush on a platform.
  assign supported = ((level_q == '0) && (y_q == FLOOR_C)) ||
                     (plat_valid && ((yS + CHARH_S) == platS));

  // Next-state and motion for one frame tick; everything holds otherwise.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    level_d     = level_q;
    facing_d    = facing_q;
    jumpVel_d   = jumpVel_q;
    landed_d    = 1'b0;
    vx_d        = vx_q;
    vy_d        = vy_q;
    chargeCnt_d = chargeCnt_q;
    xNext       = xS;
    yNext       = yS;
    vyNext      = vy_q;
    landNow     = 1'b0;
    launch      = 1'b0;
    cntInc      = chargeCnt_q + 16'd1;
    velCalc     = 16'd1 + (cntInc / DIV_C);

    if (frame_tick) begin
      unique case (state_q)
        GROUND: begin
          if (key_space) begin
            state_d     = CHARGE;
            chargeCnt_d = '0;
          end else if (!supported) begin
            state_d = AIR;
            vx_d    = ZERO_S;
            vy_d    = ZERO_S;
          end else if (key_right && !key_left) begin
            xNext = xS + WALK_S;
            if (xNext > XMAX_S) xNext = XMAX_S;
            x_d      = CW'(xNext);
            facing_d = 1'b1;
          end else if (key_left && !key_right) begin
            xNext = xS - WALK_S;
            if (xNext < ZERO_S) xNext = ZERO_S;
            x_d      = CW'(xNext);
            facing_d = 1'b0;
          end
        end

        CHARGE: begin
          // Steering keys only turn the sprite while crouched.
          if (key_left ^ key_right) facing_d = key_right;
          // Launch on release, or one tick after the charge saturates.
          launch = !key_space || (jumpVel_q == VMAX_C);
          if (launch) begin
            state_d   = AIR;
            vy_d      = toS(CW'(jumpVel_q));
            jumpVel_d = '0;
            if (key_right && !key_left)      vx_d = VXJ_S;
            else if (key_left && !key_right) vx_d = -VXJ_S;
            else                             vx_d = ZERO_S;
          end else begin
            chargeCnt_d = cntInc;
            jumpVel_d   = (velCalc > VMAX16_C) ? VMAX_C : 5'(velCalc);
          end
        end

        AIR: begin
          // Side walls reflect the horizontal drift and turn the sprite.
          xNext = xS + vx_q;
          if (xNext < ZERO_S) begin
            xNext    = ZERO_S;
            vx_d     = -vx_q;
            facing_d = !facing_q;
          end else if (xNext > XMAX_S) begin
            xNext    = XMAX_S;
            vx_d     = -vx_q;
            facing_d = !facing_q;
          end

          // Gravity: one unit per tick, capped at terminal fall speed.
          yNext  = yS - vy_q;
          vyNext = vy_q - ONE_S;
          if (vyNext < NEG_VFALL_S) vyNext = NEG_VFALL_S;

          // Landing only while not rising; a platform the feet swept past
          // this tick wins over the bottom floor.
          if (vy_q <= ZERO_S) begin
            if (plat_valid && ((yS + CHARH_S) <= platS) &&
                (platS <= (yNext + CHARH_S))) begin
              yNext   = platS - CHARH_S;
              landNow = 1'b1;
            end else if ((level_q == '0) && (yNext >= FLOOR_S)) begin
              yNext   = FLOOR_S;
              landNow = 1'b1;
            end
          end

          // Screen transitions are skipped on a landing tick.
          if (!landNow) begin
            if (yNext < ZERO_S) begin
              if (level_q < LEVEL_TOP) begin
                level_d = level_q + 1'b1;
                yNext   = yNext + FLOOR_S;
              end else begin
                yNext  = ZERO_S;
                vyNext = ZERO_S;
              end
            end else if ((yNext > FLOOR_S) && (level_q != '0)) begin
              level_d = level_q - 1'b1;
              yNext   = yNext - FLOOR_S;
            end
          end

          x_d = CW'(xNext);
          y_d = CW'(yNext);
          if (landNow) begin
            state_d  = GROUND;
            vx_d     = ZERO_S;
            vy_d     = ZERO_S;
            landed_d = 1'b1;
          end else begin
            vy_d = vyNext;
          end
        end

        default: state_d = GROUND;
      endcase
    end
  end

  // State register; reset wins over a frame tick in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= GROUND;
      x_q         <= X_INIT_C;
      y_q         <= FLOOR_C;
      level_q     <= '0;
      facing_q    <= 1'b1;
      jumpVel_q   <= '0;
      landed_q    <= 1'b0;
      vx_q        <= ZERO_S;
      vy_q        <= ZERO_S;
      chargeCnt_q <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      level_q     <= level_d;
      facing_q    <= facing_d;
      jumpVel_q   <= jumpVel_d;
      landed_q    <= landed_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      chargeCnt_q <= chargeCnt_d;
    end
  end

  // Airborne pose splits on the direction of the registered velocity.
  always_comb begin
    character_state = 2'b00;
    unique case (state_q)
      GROUND:  character_state = 2'b00;
      CHARGE:  character_state = 2'b01;
      AIR:     character_state = (vy_q > ZERO_S) ? 2'b10 : 2'b11;
      default: character_state = 2'b00;
    endcase
  end

  assign value_x  = x_q;
  assign value_y  = y_q;
  assign facing   = facing_q;
  assign level    = level_q;
  assign jump_vel = jumpVel_q;
  assign landed   = landed_q;

endmodule

// File: tb/tb_char_motion_ctl.sv
// Directed bench for char_motion_ctl. Instance A uses default geometry;
// instance B uses a 200-pixel-high, two-level screen so that level crossing,
// the ceiling, platform landing and the drop back to level 0 happen within a
// few dozen ticks. Each instance has its own frame_tick and reset; keys and
// the platform inputs are shared since only the ticked instance samples them.
module tb_char_motion_ctl;

  logic        clk = 1'b0;
  logic        rstA = 1'b0, rstB = 1'b0;
  logic        tickA = 1'b0, tickB = 1'b0;
  logic        keySpace = 1'b0, keyLeft = 1'b0, keyRight = 1'b0;
  logic        platValid = 1'b0;
  logic [11:0] platTop = 12'd0;

  logic [11:0] xA, yA, xB, yB;
  logic [1:0]  stA, stB;
  logic        faceA, faceB, landedA, landedB;
  logic [1:0]  levelA;
  logic [0:0]  levelB;
  logic [4:0]  velA, velB;

  int checks = 0;
  int errors = 0;
  int n;

  int jumpY  [7] = '{702, 700, 699, 699, 700, 702, 705};
  int jumpSt [7] = '{2, 2, 3, 3, 3, 3, 0};
  int jumpL  [7] = '{0, 0, 0, 0, 0, 0, 1};
  int wallX  [7] = '{974, 976, 972, 968, 964, 960, 956};
  int wallF  [7] = '{1, 0, 0, 0, 0, 0, 0};
  int riseY  [6] = '{113, 90, 68, 47, 27, 8};

  always #5 clk = ~clk;

  char_motion_ctl dutA (
    .clk(clk), .rst(rstA), .frame_tick(tickA),
    .key_space(keySpace), .key_left(keyLeft), .key_right(keyRight),
    .plat_valid(platValid), .plat_top(platTop),
    .value_x(xA), .value_y(yA), .character_state(stA), .facing(faceA),
    .level(levelA), .jump_vel(velA), .landed(landedA)
  );

  char_motion_ctl #(.SCREEN_H(200), .LEVELS(2)) dutB (
    .clk(clk), .rst(rstB), .frame_tick(tickB),
    .key_space(keySpace), .key_left(keyLeft), .key_right(keyRight),
    .plat_valid(platValid), .plat_top(platTop),
    .value_x(xB), .value_y(yB), .character_state(stB), .facing(faceB),
    .level(levelB), .jump_vel(velB), .landed(landedB)
  );

  // One clock with the chosen frame ticks; returns on the following negedge.
  task automatic applyStimulus(input logic selA, input logic selB);
    tickA = selA;
    tickB = selB;
    @(negedge clk);
    tickA = 1'b0;
    tickB = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    @(negedge clk);
    rstA = 1'b1;
    rstB = 1'b1;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    rstA = 1'b0;
    rstB = 1'b0;

    $display("[TB] reset state");
    checkOutput("rstX", 32'(xA), 488);
    checkOutput("rstY", 32'(yA), 705);
    checkOutput("rstSt", 32'(stA), 0);
    checkOutput("rstFace", 32'(faceA), 1);
    checkOutput("rstLevel", 32'(levelA), 0);
    checkOutput("rstVel", 32'(velA), 0);
    checkOutput("rstLanded", 32'(landedA), 0);
    checkOutput("rstYB", 32'(yB), 137);
    checkOutput("rstFaceB", 32'(faceB), 1);

    $display("[TB] idle ticks");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("idleX", 32'(xA), 488);
      checkOutput("idleY", 32'(yA), 705);
      checkOutput("idleSt", 32'(stA), 0);
      checkOutput("idleLanded", 32'(landedA), 0);
    end

    $display("[TB] walking");
    keyRight = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("walk1X", 32'(xA), 490);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("walk10X", 32'(xA), 508);
    checkOutput("walk10Face", 32'(faceA), 1);
    keyLeft = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("bothX", 32'(xA), 508);
    keyRight = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("leftX", 32'(xA), 506);
    checkOutput("leftFace", 32'(faceA), 0);
    keyLeft = 1'b0;
    keyRight = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("rightX", 32'(xA), 508);
    checkOutput("rightFace", 32'(faceA), 1);
    keyRight = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkOutput("noTickX", 32'(xA), 508);

    $display("[TB] charge and vertical jump");
    keySpace = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("chgEnterSt", 32'(stA), 1);
    checkOutput("chgEnterVel", 32'(velA), 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("chg1Vel", 32'(velA), 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("chg4Vel", 32'(velA), 2);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("chg8Vel", 32'(velA), 3);
    checkOutput("chg8X", 32'(xA), 508);
    keySpace = 1'b0;
    applyStimulus(1'b1, 1'b0);
    checkOutput("launchSt", 32'(stA), 2);
    checkOutput("launchVel", 32'(velA), 0);
    checkOutput("launchY", 32'(yA), 705);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("jumpY", 32'(yA), 32'(jumpY[k]));
      checkOutput("jumpSt", 32'(stA), 32'(jumpSt[k]));
      checkOutput("jumpLanded", 32'(landedA), 32'(jumpL[k]));
      checkOutput("jumpX", 32'(xA), 508);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("landedClear", 32'(landedA), 0);
    checkOutput("holdY", 32'(yA), 705);

    $display("[TB] wall bounce");
    keyRight = 1'b1;
    for (int i = 0; i < 231; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("walkTo970", 32'(xA), 970);
    keyRight = 1'b0;
    keySpace = 1'b1;
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0);
    keySpace = 1'b0;
    keyRight = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("wallLaunchSt", 32'(stA), 2);
    keyRight = 1'b0;
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("wallX", 32'(xA), 32'(wallX[k]));
      checkOutput("wallFace", 32'(faceA), 32'(wallF[k]));
      checkOutput("wallY", 32'(yA), 32'(jumpY[k]));
    end
    checkOutput("wallLanded", 32'(landedA), 1);
    checkOutput("wallLandSt", 32'(stA), 0);

    $display("[TB] walk clamp at right edge");
    keyRight = 1'b1;
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("clampX", 32'(xA), 976);
    keyRight = 1'b0;
    keyLeft = 1'b1;
    applyStimulus(1'b1, 1'b0);
    checkOutput("offEdgeX", 32'(xA), 974);
    keyLeft = 1'b0;

    $display("[TB] reset during charge and mid-air");
    keySpace = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("preRstVel", 32'(velA), 2);
    rstA = 1'b1;
    applyStimulus(1'b1, 1'b0);
    rstA = 1'b0;
    checkOutput("chgRstVel", 32'(velA), 0);
    checkOutput("chgRstSt", 32'(stA), 0);
    checkOutput("chgRstX", 32'(xA), 488);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0);
    keySpace = 1'b0;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("airY", 32'(yA), 700);
    checkOutput("airSt", 32'(stA), 2);
    rstA = 1'b1;
    keyLeft = 1'b1;
    applyStimulus(1'b1, 1'b0);
    rstA = 1'b0;
    keyLeft = 1'b0;
    checkOutput("airRstX", 32'(xA), 488);
    checkOutput("airRstY", 32'(yA), 705);
    checkOutput("airRstSt", 32'(stA), 0);
    checkOutput("airRstFace", 32'(faceA), 1);
    checkOutput("airRstLevel", 32'(levelA), 0);
    checkOutput("airRstLanded", 32'(landedA), 0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("postRstY", 32'(yA), 705);
    checkOutput("postRstSt", 32'(stA), 0);

    $display("[TB] auto-launch and level crossing");
    keySpace = 1'b1;
    applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 92; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("fullVel", 32'(velB), 24);
    checkOutput("fullSt", 32'(stB), 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("autoSt", 32'(stB), 2);
    checkOutput("autoVel", 32'(velB), 0);
    checkOutput("autoY", 32'(yB), 137);
    keySpace = 1'b0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 1'b1);
      checkOutput("riseY", 32'(yB), 32'(riseY[k]));
      checkOutput("riseLevel", 32'(levelB), 0);
    end
    applyStimulus(1'b0, 1'b1);
    checkOutput("crossY", 32'(yB), 127);
    checkOutput("crossLevel", 32'(levelB), 1);
    checkOutput("crossSt", 32'(stB), 2);

    $display("[TB] ceiling and platform landing");
    platValid = 1'b1;
    platTop = 12'd190;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("nearTopY", 32'(yB), 2);
    applyStimulus(1'b0, 1'b1);
    checkOutput("bonkY", 32'(yB), 0);
    checkOutput("bonkSt", 32'(stB), 3);
    checkOutput("bonkLevel", 32'(levelB), 1);
    n = 0;
    while (!landedB && n < 40) begin
      applyStimulus(1'b0, 1'b1);
      n++;
    end
    checkOutput("platTicks", 32'(n), 17);
    checkOutput("platY", 32'(yB), 127);
    checkOutput("platLevel", 32'(levelB), 1);
    checkOutput("platSt", 32'(stB), 0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("platLandedClear", 32'(landedB), 0);

    $display("[TB] drop back to level 0");
    platValid = 1'b0;
    applyStimulus(1'b0, 1'b1);
    checkOutput("dropSt", 32'(stB), 3);
    checkOutput("dropY", 32'(yB), 127);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("dropEdgeY", 32'(yB), 137);
    checkOutput("dropEdgeLevel", 32'(levelB), 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("downY", 32'(yB), 5);
    checkOutput("downLevel", 32'(levelB), 0);
    checkOutput("downX", 32'(xB), 488);
    n = 0;
    while (!landedB && n < 40) begin
      applyStimulus(1'b0, 1'b1);
      n++;
    end
    checkOutput("floorTicks", 32'(n), 12);
    checkOutput("floorY", 32'(yB), 137);
    checkOutput("floorLevel", 32'(levelB), 0);
    checkOutput("floorSt", 32'(stB), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
